// File: rtl/tc_clk_gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tc_clk_pkg
//   Shared types for the clock-gate sequencer.
//   - clk_gate_state_e : per-channel FSM state. The encoding is visible on
//                        state_o, so the values are fixed.
//   - cnt_width()      : width of a down-counter that is loaded with n-1.
//                        The result is never smaller than 1 bit, so that
//                        SETTLE_CYC=1 and DRAIN_CYC=1 still elaborate.
// -----------------------------------------------------------------------------
package tc_clk_pkg;

    typedef enum logic [1:0] {
        GATED    = 2'd0,
        WAKING   = 2'd1,
        RUNNING  = 2'd2,
        DRAINING = 2'd3
    } clk_gate_state_e;

    // Counter width needed to hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tc_clk_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// tc_clk_gate_ctrl_if
//   Requester-side bundle of the clock-gate sequencer.
//   Handshake: req_i[n] (or sw_on_i[n]) is a level request for domain n.
//   ack_o[n] high means the domain clock has settled and stays enabled for as
//   long as ack_o[n] is high. A requester uses the domain only while both its
//   request and ack_o[n] are high. Dropping the request starts the idle timeout.
//   Signals:
//     req_i    [NUM_CH]    requester wake level
//     sw_on_i  [NUM_CH]    software force-on, which acts as a held request
//     ack_o    [NUM_CH]    domain clock stable and guaranteed on
//     clk_en_o [NUM_CH]    enables to the integrator's gate cells
//     state_o  [2*NUM_CH]  per-channel FSM state; channel n is at [2n+1:2n]
//     busy_o               some channel is not GATED
//   The master modport is the requester/bench side. The slave modport is the
//   sequencer side.
// -----------------------------------------------------------------------------
interface tc_clk_gate_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   req_i;
    logic [NUM_CH-1:0]   sw_on_i;
    logic [NUM_CH-1:0]   ack_o;
    logic [NUM_CH-1:0]   clk_en_o;
    logic [2*NUM_CH-1:0] state_o;
    logic                busy_o;

    modport master (
        output req_i, sw_on_i,
        input  ack_o, clk_en_o, state_o, busy_o
    );

    modport slave (
        input  req_i, sw_on_i,
        output ack_o, clk_en_o, state_o, busy_o
    );
endinterface

// File: rtl/tc_clk_gate_ctrl_chan.sv
// -----------------------------------------------------------------------------
// tc_clk_gate_chan
//   Sequencer for a single gated domain. It holds the FSM and its
//   settle, drain and idle counters.
//   Ports:
//     clk_i, rst_ni   root clock, synchronous active-low reset
//     wake_i          req | sw_on for this channel
//     gate_en_i       0 forces the channel to RUNNING and holds the counters at 0
//     idle_thresh_i   idle cycles tolerated in RUNNING before draining
//     ack_o           high in RUNNING
//     en_o            high in every state except GATED
//     state_o         current FSM state
//   ack_o and en_o are decoded from the state register only, so they behave
//   as registered outputs.
// -----------------------------------------------------------------------------
module tc_clk_gate_chan
    import tc_clk_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int DRAIN_CYC  = 4,
    parameter int IDLE_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wake_i,
    input  logic              gate_en_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    output logic              ack_o,
    output logic              en_o,
    output clk_gate_state_e   state_o
);
    localparam int SETTLE_W = cnt_width(SETTLE_CYC);
    localparam int DRAIN_W  = cnt_width(DRAIN_CYC);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LOAD  = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [IDLE_W-1:0]   IDLE_MAX    = '1;

    clk_gate_state_e     state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        if (!gate_en_i) begin
            // Gating is disabled, so the domain is free-running from any state.
            state_d      = RUNNING;
            settle_cnt_d = '0;
            drain_cnt_d  = '0;
            idle_cnt_d   = '0;
        end else begin
            case (state_q)
                GATED: begin
                    if (wake_i) begin
                        state_d      = WAKING;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
                WAKING: begin
                    // A wake that drops here does not abort the settle.
                    if (settle_cnt_q == '0) begin
                        state_d    = RUNNING;
                        idle_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                    end
                end
                RUNNING: begin
                    if (wake_i) begin
                        idle_cnt_d = '0;
                    end else if ((idle_cnt_q == idle_thresh_i) || (idle_cnt_q == IDLE_MAX)) begin
                        // The saturation term lets a threshold lowered below the
                        // running count still drain once the counter tops out.
                        state_d     = DRAINING;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                DRAINING: begin
                    // The clock never stopped, so a new wake needs no re-settle.
                    if (wake_i) begin
                        state_d    = RUNNING;
                        idle_cnt_d = '0;
                    end else if (drain_cnt_q == '0) begin
                        state_d = GATED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    end
                end
                default: state_d = GATED;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= GATED;
            settle_cnt_q <= '0;
            drain_cnt_q  <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign ack_o   = (state_q == RUNNING);
    assign en_o    = (state_q != GATED);
    assign state_o = state_q;

endmodule

// File: rtl/tc_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tc_clk_gate_ctrl
//   Per-channel clock-gate sequencer running on the root clock. It produces
//   the en_i inputs of NUM_CH clock-gating cells. The integrator instantiates
//   those cells outside this block.
//   Ports:
//     clk_i          root clock (ungated)
//     rst_ni         synchronous active-low reset
//     gate_en_i      0: gating disabled, all domains forced to RUNNING
//     test_en_i      forces clk_en_o to all-ones; ack and the FSMs are unaffected
//     idle_thresh_i  idle cycles tolerated in RUNNING before draining
//     bus            req/sw_on in; ack/clk_en/state/busy out (slave modport)
// -----------------------------------------------------------------------------
module tc_clk_gate_ctrl
    import tc_clk_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SETTLE_CYC = 2,
    parameter int DRAIN_CYC  = 4,
    parameter int IDLE_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              gate_en_i,
    input  logic              test_en_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    tc_clk_gate_ctrl_if.slave bus
);
    logic [NUM_CH-1:0] ack_w;
    logic [NUM_CH-1:0] en_w;
    logic [NUM_CH-1:0] busy_w;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        clk_gate_state_e st_w;

        tc_clk_gate_chan #(
            .SETTLE_CYC (SETTLE_CYC),
            .DRAIN_CYC  (DRAIN_CYC),
            .IDLE_W     (IDLE_W)
        ) u_chan (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .wake_i        (bus.req_i[n] | bus.sw_on_i[n]),
            .gate_en_i     (gate_en_i),
            .idle_thresh_i (idle_thresh_i),
            .ack_o         (ack_w[n]),
            .en_o          (en_w[n]),
            .state_o       (st_w)
        );

        assign bus.state_o[2*n +: 2] = st_w;
        assign busy_w[n]             = (st_w != GATED);

        // The domain clock is on whenever ack is high, and it stays on in the cycle after.
        a_ack_en  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     bus.ack_o[n] |-> bus.clk_en_o[n]);
        a_en_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     bus.ack_o[n] |=> bus.clk_en_o[n]);
    end

    // test_en is the only combinational path to an output.
    assign bus.clk_en_o = en_w | {NUM_CH{test_en_i}};
    assign bus.ack_o    = ack_w;
    assign bus.busy_o   = |busy_w;

endmodule
